// File: rtl/serial_pkg.sv
// Shared types and constants for the serial frame transmitter.
// SERIAL_TX_PARITY_EN selects whether PARITY_EN reports an even-parity bit in the frame.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic SO_IDLE   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Clocks per frame: start + data + optional parity + stop.
  function automatic int frame_clks(input int data_w, input int clks_per_bit, input bit parity_en);
    return (data_w + 2 + (parity_en ? 1 : 0)) * clks_per_bit;
  endfunction

  // Even parity over a zero-extended data word.
  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks while enabled and flags the
// last clock of each bit. Cleared on frame accept and on reset.
module serial_bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          last_s;

  // Next count: restart on clear, wrap only at the end of a bit period.
  always_comb begin
    cnt_d  = cnt_q;
    last_s = (cnt_q == LAST_CNT);
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (last_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = en_i & last_s & ~clr_i;

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W bits LSB first, stop bit.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              so,
  output logic              busy
);

  localparam int BCW = $clog2(DATA_W) + 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              so_q, so_d;
  logic              busy_q, busy_d;
  logic              tx_ready_q, tx_ready_d;
  logic              accept_s;
  logic              bit_done_s;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign accept_s = tx_valid & tx_ready_q;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (accept_s),
    .en_i       (busy_q),
    .bit_done_o (bit_done_s)
  );

  // Frame sequencing; all outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    so_d       = so_q;
    busy_d     = busy_q;
    tx_ready_d = tx_ready_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        so_d   = SO_IDLE;
        busy_d = 1'b0;
        if (accept_s) begin
          state_d    = ST_START;
          shift_d    = tx_data;
          bit_cnt_d  = '0;
          so_d       = START_BIT;
          busy_d     = 1'b1;
          tx_ready_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d   = even_parity(32'(tx_data));
`endif
        end else begin
          tx_ready_d = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          state_d   = ST_DATA;
          so_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end else begin
          so_d = START_BIT;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = ST_PARITY;
            so_d    = parity_q;
`else
            state_d = ST_STOP;
            so_d    = STOP_BIT;
`endif
          end else begin
            so_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          so_d = so_q;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done_s) begin
          state_d = ST_STOP;
          so_d    = STOP_BIT;
        end else begin
          so_d = so_q;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done_s) begin
          state_d    = ST_IDLE;
          so_d       = SO_IDLE;
          busy_d     = 1'b0;
          tx_ready_d = 1'b1;
        end else begin
          so_d = STOP_BIT;
        end
      end
      default: begin
        // Unreachable encodings fall back to a safe idle line.
        state_d    = ST_IDLE;
        so_d       = SO_IDLE;
        busy_d     = 1'b0;
        tx_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      so_q       <= SO_IDLE;
      busy_q     <= 1'b0;
      tx_ready_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      so_q       <= so_d;
      busy_q     <= busy_d;
      tx_ready_q <= tx_ready_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_ready = tx_ready_q;
  assign so       = so_q;
  assign busy     = busy_q;

endmodule
